// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: byte-strobe writes, read-only masking, SLVERR on decode miss.
// Optional hardware load ports are enabled by defining AXI_LITE_REG_BANK_HW_LOAD_EN.
module axi_lite_reg_bank #(
   parameter int unsigned              AW       = 32,
   parameter int unsigned              DW       = 32,
   parameter int unsigned              NumRegs  = 8,
   parameter logic [AW-1:0]            BaseAddr = '0,
   parameter logic [NumRegs-1:0]       RoMask   = '0,
   parameter logic [NumRegs*DW-1:0]    RstVal   = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [AW-1:0]           aw_addr_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [DW-1:0]           w_data_i,
   input  logic [DW/8-1:0]         w_strb_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   output logic [1:0]              b_resp_o,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   input  logic [AW-1:0]           ar_addr_i,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   output logic [DW-1:0]           r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic [NumRegs*DW-1:0]   reg_q_o,
   output logic [NumRegs-1:0]      reg_wr_o
`ifdef AXI_LITE_REG_BANK_HW_LOAD_EN
   ,
   input  logic [NumRegs-1:0]      reg_load_i,
   input  logic [NumRegs*DW-1:0]   reg_d_i
`endif
);

   localparam int unsigned SW   = DW / 8;
   localparam int unsigned OffW = $clog2(SW);
   localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlvErr = 2'b10;

   logic                          active_q;
   logic                          aw_held_q, w_held_q;
   logic [AW-1:0]                 aw_addr_q;
   logic [DW-1:0]                 w_data_q;
   logic [SW-1:0]                 w_strb_q;
   logic                          b_valid_q, r_valid_q;
   logic [1:0]                    b_resp_q, r_resp_q;
   logic [DW-1:0]                 r_data_q;
   logic [NumRegs-1:0][DW-1:0]    regs_q, regs_d;
   logic [NumRegs-1:0]            reg_wr_q, reg_wr_d;

   logic                          aw_hs, w_hs, ar_hs, commit;
   logic                          wr_hit, wr_ok, rd_hit;
   logic [IdxW-1:0]               wr_idx, rd_idx;

   function automatic logic addr_hit(input logic [AW-1:0] addr);
      logic [AW-1:0] off;
      off = addr - BaseAddr;
      return (addr >= BaseAddr) && ((off >> OffW) < AW'(NumRegs));
   endfunction

   function automatic logic [IdxW-1:0] addr_idx(input logic [AW-1:0] addr);
      logic [AW-1:0] off;
      off = addr - BaseAddr;
      return IdxW'(off >> OffW);
   endfunction

   // Readies are held low until the first cycle after reset release.
   assign aw_ready_o = active_q & ~aw_held_q;
   assign w_ready_o  = active_q & ~w_held_q;
   assign ar_ready_o = active_q & (~r_valid_q | r_ready_i);

   assign aw_hs  = aw_valid_i & aw_ready_o;
   assign w_hs   = w_valid_i & w_ready_o;
   assign ar_hs  = ar_valid_i & ar_ready_o;
   assign commit = aw_held_q & w_held_q & (~b_valid_q | b_ready_i);

   assign wr_hit = addr_hit(aw_addr_q);
   assign wr_idx = addr_idx(aw_addr_q);
   assign wr_ok  = wr_hit && !RoMask[wr_idx];
   assign rd_hit = addr_hit(ar_addr_i);
   assign rd_idx = addr_idx(ar_addr_i);

   // Next register contents: bus byte writes, then hardware loads take priority.
   always_comb begin
      regs_d   = regs_q;
      reg_wr_d = '0;
      if (commit && wr_ok) begin
         for (int unsigned b = 0; b < SW; b++) begin
            if (w_strb_q[b]) regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
         end
         reg_wr_d[wr_idx] = |w_strb_q;
      end
`ifdef AXI_LITE_REG_BANK_HW_LOAD_EN
      for (int unsigned i = 0; i < NumRegs; i++) begin
         if (reg_load_i[i]) regs_d[i] = reg_d_i[i*DW +: DW];
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         active_q  <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
         b_resp_q  <= RespOkay;
         r_valid_q <= 1'b0;
         r_resp_q  <= RespOkay;
         r_data_q  <= '0;
         regs_q    <= RstVal;
         reg_wr_q  <= '0;
      end else begin
         active_q <= 1'b1;
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_addr_q <= aw_addr_i;
         end else if (commit) begin
            aw_held_q <= 1'b0;
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= w_data_i;
            w_strb_q <= w_strb_i;
         end else if (commit) begin
            w_held_q <= 1'b0;
         end
         if (commit) begin
            b_valid_q <= 1'b1;
            b_resp_q  <= wr_ok ? RespOkay : RespSlvErr;
         end else if (b_ready_i) begin
            b_valid_q <= 1'b0;
         end
         // Reads sample the pre-commit register value.
         if (ar_hs) begin
            r_valid_q <= 1'b1;
            r_data_q  <= rd_hit ? regs_q[rd_idx] : '0;
            r_resp_q  <= rd_hit ? RespOkay : RespSlvErr;
         end else if (r_ready_i) begin
            r_valid_q <= 1'b0;
         end
         regs_q   <= regs_d;
         reg_wr_q <= reg_wr_d;
      end
   end

   assign b_valid_o = b_valid_q;
   assign b_resp_o  = b_resp_q;
   assign r_valid_o = r_valid_q;
   assign r_data_o  = r_data_q;
   assign r_resp_o  = r_resp_q;
   assign reg_q_o   = regs_q;
   assign reg_wr_o  = reg_wr_q;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axi_lite_reg_bank;

   localparam int unsigned N = 8;
   localparam logic [N-1:0]    RO   = 8'h01;
   localparam logic [N*32-1:0] RSTV = {32'hA0B0C0D7, 32'hA0B0C0D6, 32'hA0B0C0D5, 32'hA0B0C0D4,
                                       32'hA0B0C0D3, 32'hA0B0C0D2, 32'hA0B0C0D1, 32'hA0B0C0D0};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   aw_addr, w_data, ar_addr, r_data;
   logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic          ar_valid, ar_ready, r_valid, r_ready;
   logic [3:0]    w_strb;
   logic [1:0]    b_resp, r_resp;
   logic [N*32-1:0] reg_q;
   logic [N-1:0]  reg_wr;

   always #5 clk = ~clk;

   axi_lite_reg_bank #(
      .AW(32), .DW(32), .NumRegs(N), .BaseAddr(32'h0), .RoMask(RO), .RstVal(RSTV)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
      .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
      .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
      .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
      .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
      .reg_q_o(reg_q), .reg_wr_o(reg_wr)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: one word per register, decoded from the byte address.
   logic [31:0] model [N];

   task automatic model_reset();
      logic [N*32-1:0] rv;
      rv = RSTV;
      for (int i = 0; i < N; i++) model[i] = rv[i*32 +: 32];
   endtask

   function automatic logic [N*32-1:0] model_flat();
      logic [N*32-1:0] f;
      for (int i = 0; i < N; i++) f[i*32 +: 32] = model[i];
      return f;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp, output logic [N-1:0] pulse);
      int idx;
      idx   = int'(addr / 4);
      pulse = '0;
      if (addr >= N * 4 || RO[idx]) begin
         resp = 2'b10;
      end else begin
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
         if (strb != 0) pulse[idx] = 1'b1;
         resp = 2'b00;
      end
   endtask

   task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      if (addr >= N * 4) begin
         data = 32'h0;
         resp = 2'b10;
      end else begin
         data = model[addr / 4];
         resp = 2'b00;
      end
   endtask

   // Called and returns at a falling edge; b_ready must be 1.
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [N-1:0] pulse, output int lat);
      logic aw_go, w_go, ok;
      aw_addr = addr; aw_valid = 1'b1;
      w_data = data; w_strb = strb; w_valid = 1'b1;
      for (int n = 0; n < 20 && (aw_valid || w_valid); n++) begin
         aw_go = aw_valid && aw_ready;
         w_go  = w_valid && w_ready;
         @(negedge clk);
         if (aw_go) aw_valid = 1'b0;
         if (w_go) w_valid = 1'b0;
      end
      check("wr_accept", {aw_valid, w_valid}, 2'b00);
      aw_valid = 1'b0; w_valid = 1'b0;
      lat = 0; ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (b_valid) begin ok = 1'b1; break; end
         lat++;
         @(negedge clk);
      end
      check("wr_bvalid", ok, 1'b1);
      resp = b_resp; pulse = reg_wr;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
      logic go, ok;
      ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         go = ar_ready;
         @(negedge clk);
         if (go) begin ar_valid = 1'b0; break; end
      end
      check("rd_accept", ar_valid, 1'b0);
      ar_valid = 1'b0;
      lat = 0; ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (r_valid) begin ok = 1'b1; break; end
         lat++;
         @(negedge clk);
      end
      check("rd_rvalid", ok, 1'b1);
      data = r_data; resp = r_resp;
      @(negedge clk);
   endtask

   logic [31:0]   rd, ed, nv, od, a, d;
   logic [1:0]    rsp, ersp;
   logic [N-1:0]  pl, epl;
   logic [3:0]    s;
   int            lat;

   initial begin
      rst_n = 1'b0;
      aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0;
      ar_addr = '0; ar_valid = 1'b0; b_ready = 1'b1; r_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_ready", {aw_ready, w_ready, ar_ready}, 3'b000);
      check("rst_valid", {b_valid, r_valid}, 2'b00);
      check("rst_resp_data", {b_resp, r_resp, r_data}, 36'h0);
      check("rst_regwr", reg_wr, 8'h00);
      check("rst_regs", reg_q, RSTV);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
      model_reset();

      // Same-cycle AW/W write then read-back
      bus_write(32'h4, 32'hDEADBEEF, 4'hF, rsp, pl, lat);
      model_write(32'h4, 32'hDEADBEEF, 4'hF, ersp, epl);
      check("t1_bresp", rsp, 2'b00);
      check("t1_blat", lat, 1);
      check("t1_pulse", pl, 8'h02);
      bus_read(32'h4, rd, rsp, lat);
      check("t1_rdata", rd, 32'hDEADBEEF);
      check("t1_rresp", rsp, 2'b00);
      check("t1_rlat", lat, 0);

      // W first, AW three cycles later, B back-pressured
      w_data = 32'h000000AA; w_strb = 4'h1; w_valid = 1'b1; b_ready = 1'b0;
      @(negedge clk); w_valid = 1'b0;
      check("t2_w_held", w_ready, 1'b0);
      repeat (2) @(negedge clk);
      aw_addr = 32'h8; aw_valid = 1'b1;
      @(negedge clk); aw_valid = 1'b0;
      @(negedge clk);
      check("t2_bvalid", b_valid, 1'b1);
      check("t2_bresp", b_resp, 2'b00);
      model_write(32'h8, 32'h000000AA, 4'h1, ersp, epl);
      nv = $urandom;
      aw_addr = 32'hC; aw_valid = 1'b1; w_data = nv; w_strb = 4'hF; w_valid = 1'b1;
      @(negedge clk); aw_valid = 1'b0; w_valid = 1'b0;
      aw_addr = 32'h10; aw_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t2_aw_blocked", {aw_ready, w_ready}, 2'b00);
         check("t2_bhold", {b_valid, b_resp}, 3'b100);
      end
      aw_valid = 1'b0; b_ready = 1'b1;
      @(negedge clk);
      check("t2_b2", {b_valid, b_resp}, 3'b100);
      model_write(32'hC, nv, 4'hF, ersp, epl);
      @(negedge clk);
      check("t2_bdone", b_valid, 1'b0);
      check("t2_regs", reg_q, model_flat());
      ed = (RSTV[95:64] & 32'hFFFFFF00) | 32'h000000AA;
      bus_read(32'h8, rd, rsp, lat);
      check("t2_reg2", rd, ed);

      // Write to read-only register 0
      bus_write(32'h0, 32'h11111111, 4'hF, rsp, pl, lat);
      model_write(32'h0, 32'h11111111, 4'hF, ersp, epl);
      check("t3_bresp", rsp, 2'b10);
      check("t3_pulse", pl, epl);
      check("t3_regs", reg_q, model_flat());
      bus_read(32'h0, rd, rsp, lat);
      check("t3_rdata", rd, RSTV[31:0]);
      check("t3_rresp", rsp, 2'b00);

      // Out-of-range read with R back-pressure
      ar_addr = 32'h20; ar_valid = 1'b1; r_ready = 1'b0;
      @(negedge clk); ar_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t4_rhold", {r_valid, r_resp, r_data}, {1'b1, 2'b10, 32'h0});
         check("t4_ar_block", ar_ready, 1'b0);
         @(negedge clk);
      end
      r_ready = 1'b1; #1;
      check("t4_ar_rise", ar_ready, 1'b1);
      @(negedge clk);
      check("t4_rdone", r_valid, 1'b0);

      // Back-to-back reads of 0xC across a write commit
      od = model[3]; nv = $urandom;
      aw_addr = 32'hC; aw_valid = 1'b1; w_data = nv; w_strb = 4'hF; w_valid = 1'b1;
      ar_addr = 32'hC; ar_valid = 1'b1;
      @(negedge clk); aw_valid = 1'b0; w_valid = 1'b0;
      check("t5_rd_pre", {r_valid, r_data}, {1'b1, od});
      @(negedge clk);
      check("t5_rd_commit", {r_valid, r_data}, {1'b1, od});
      check("t5_b", {b_valid, b_resp}, 3'b100);
      model_write(32'hC, nv, 4'hF, ersp, epl);
      @(negedge clk); ar_valid = 1'b0;
      check("t5_rd_post", {r_valid, r_data}, {1'b1, model[3]});
      @(negedge clk);
      check("t5_rdone", r_valid, 1'b0);

      // Reset with AW held and B pending
      aw_addr = 32'h10; aw_valid = 1'b1; w_data = 32'h55AA55AA; w_strb = 4'hF; w_valid = 1'b1;
      b_ready = 1'b0;
      @(negedge clk); aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      check("t6_bpend", b_valid, 1'b1);
      aw_addr = 32'h14; aw_valid = 1'b1;
      @(negedge clk); aw_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      check("t6_bclr", b_valid, 1'b0);
      check("t6_regs", reg_q, RSTV);
      check("t6_rdy_low", {aw_ready, w_ready, ar_ready}, 3'b000);
      @(negedge clk);
      check("t6_rdy_rise", {aw_ready, w_ready, ar_ready}, 3'b111);
      check("t6_bstill", b_valid, 1'b0);
      b_ready = 1'b1;
      model_reset();

      // Randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         a = {26'h0, 4'($urandom_range(0, 9)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            bus_write(a, d, s, rsp, pl, lat);
            model_write(a, d, s, ersp, epl);
            check("rnd_bresp", rsp, ersp);
            check("rnd_pulse", pl, epl);
            check("rnd_regs", reg_q, model_flat());
         end else begin
            bus_read(a, rd, rsp, lat);
            model_read(a, ed, ersp);
            check("rnd_rdata", rd, ed);
            check("rnd_rresp", rsp, ersp);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
